// File: rtl/uart_rx_apb_periph.sv
// ---------------------------------------------------------------------------
// uart_rx_apb_periph
//
// APB slave UART receiver. Frames on `rx` are sampled at OVS ticks per bit
// through a 2-flop synchroniser. Good bytes are pushed into a small FIFO that
// the CPU drains over APB.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. The
// parity bit is checked and bad bytes are dropped with perr set. Without the
// macro the frame is 8N1 and STAT[4] always reads 0.
//
// Ports
//   PCLK     clock; all state changes on its rising edge
//   PRESET   synchronous active-high reset
//   PADDR    APB byte address, only [3:2] decoded
//   PWDATA   APB write data
//   PWRITE   APB write strobe
//   PENABLE  APB access phase
//   PSEL     APB select
//   PRDATA   registered APB read data
//   PREADY   registered APB ready (one wait state per transfer)
//   rx       asynchronous serial input, idle high
//
// Register map (PADDR[3:2])
//   0 STAT  R: [0] empty [1] full [2] ovr [3] ferr [4] perr; W: W1C on [4:2]
//   1 RXD   R: FIFO head (pops one entry) or 0 when empty; W: ignored
//   2,3     read 0, writes ignored
// ---------------------------------------------------------------------------
module uart_rx_apb_periph #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16,
  parameter int FIFO_AW  = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVS);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // -------------------------------------------------------------------------
  // Input synchroniser: reset high so a reset never looks like a start bit.
  // -------------------------------------------------------------------------
  logic rx_m, rx_s;

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples the values from before the edge, independent of statement
  // order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // -------------------------------------------------------------------------
  // Oversampling tick: one-cycle pulse each time the divider wraps.
  // -------------------------------------------------------------------------
  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Receive FSM
  // -------------------------------------------------------------------------
  state_t       state;
  logic [TW-1:0] tcnt;
  logic [2:0]   bcnt;
  logic [7:0]   shreg;
  logic         pbad;     // parity error seen in the current frame

  logic stop_hit, rx_push, ferr_set, perr_set;

  assign stop_hit = (state == STOP) && tick && (tcnt == T_LAST);
  assign rx_push  = stop_hit && rx_s && !pbad;
  assign ferr_set = stop_hit && !rx_s;

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign perr_set = (state == PARITY) && tick && (tcnt == T_LAST) && (^{shreg, rx_s});
`else
  assign perr_set = 1'b0;
  assign pbad     = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      pbad  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            tcnt  <= '0;
`ifdef UART_RX_PARITY_EN
            pbad  <= 1'b0;
`endif
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == T_MID) begin
              // Line back high at mid start bit is a glitch, not a frame.
              state <= rx_s ? IDLE : DATA;
              tcnt  <= '0;
              bcnt  <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tcnt == T_LAST) begin
              shreg[bcnt] <= rx_s;
              tcnt        <= '0;
              bcnt        <= bcnt + 1'b1;
              if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tcnt == T_LAST) begin
              pbad  <= ^{shreg, rx_s};
              tcnt  <= '0;
              state <= STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tcnt == T_LAST) begin
              state <= IDLE;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // APB transfer detect: a transfer starts on the first cycle PSEL&PENABLE is
  // seen; `busy` suppresses re-triggering while the master holds PENABLE.
  // -------------------------------------------------------------------------
  logic       sel_en, busy, apb_start;
  logic [1:0] reg_sel;

  assign sel_en    = PSEL && PENABLE;
  assign apb_start = sel_en && !busy;
  assign reg_sel   = PADDR[3:2];

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic               full, empty;
  logic               pop_req, do_pop, do_push, ovr_set;

  assign pop_req = apb_start && !PWRITE && (reg_sel == 2'd1);
  assign do_pop  = pop_req && !empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = rx_push && (!full || do_pop);
  assign ovr_set = rx_push && full && !do_pop;

  // NOTE: the storage array has no reset; empty/full and the pointers guard
  // every read, so clearing the data itself would only cost reset routing.
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop) begin
        empty <= 1'b0;
        full  <= (FIFO_AW'(wptr + 1'b1) == rptr);
      end else if (do_pop && !do_push) begin
        full  <= 1'b0;
        empty <= (FIFO_AW'(rptr + 1'b1) == wptr);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky status flags: a set event wins over a same-cycle W1C.
  // -------------------------------------------------------------------------
  logic       ovr, ferr, perr;
  logic [4:2] w1c;

  assign w1c = (apb_start && PWRITE && (reg_sel == 2'd0)) ? PWDATA[4:2] : 3'b000;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= (ovr  && !w1c[2]) || ovr_set;
      ferr <= (ferr && !w1c[3]) || ferr_set;
      perr <= (perr && !w1c[4]) || perr_set;
    end
  end

  // -------------------------------------------------------------------------
  // Read mux and registered APB response
  // -------------------------------------------------------------------------
  logic [31:0] rdata;

  // NOTE: rdata gets a full default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata[4:0] = {perr, ferr, ovr, full, empty};
      2'd1:    if (!empty) rdata[7:0] = mem[rptr];
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      busy   <= 1'b0;
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      busy   <= sel_en;
      PREADY <= apb_start;
      if (apb_start) PRDATA <= PWRITE ? 32'd0 : rdata;
    end
  end

  // Write data above the W1C field and the byte-lane address bits are unused.
  logic unused_bits;
  assign unused_bits = ^{PWDATA[31:5], PWDATA[1:0], PADDR[1:0]};

endmodule

// File: tb/tb_uart_rx_apb_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_apb_periph
//
// Directed bench for uart_rx_apb_periph. The DUT runs with a divider of 4 so
// one bit lasts 64 clocks. Bytes that should reach the FIFO are queued when
// their frame is sent and compared when RXD is read; the sticky flags are
// modelled alongside the queue to predict STAT.
// ---------------------------------------------------------------------------
module tb_uart_rx_apb_periph;

  localparam int DIV   = 4;
  localparam int OVS   = 16;
  localparam int BITC  = DIV * OVS;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Clock edges from the start-bit edge to the STOP sample, for a frame that
  // starts on a divider-aligned edge: 2 synchroniser flops + 1 IDLE cycle,
  // then mid start bit (OVS/2 ticks) and OVS ticks per remaining bit.
  localparam int PUSH_OFS = 3 + DIV * (OVS / 2 + OVS * (9 + PB));

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        rx = 1'b1;

  uart_rx_apb_periph #(
    .CLK_FREQ (640_000),
    .BAUD     (10_000),
    .OVS      (OVS),
    .FIFO_AW  (2)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .rx      (rx)
  );

  always #5 PCLK = ~PCLK;

  // Edges since reset release; the DUT divider is phase-locked to this.
  int cyc = 0;
  always @(posedge PCLK) cyc <= PRESET ? 0 : cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat();
    return {27'b0, m_perr, m_ferr, m_ovr, exp_q.size() == DEPTH, exp_q.size() == 0};
  endfunction

  task automatic apb_xfer(input logic wr, input logic [3:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int waits;
    waits = 99;
    rdata = '0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        waits = i;
        rdata = PRDATA;
        break;
      end
    end
    check("pready_wait", waits, 1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("pready_drop", {31'b0, PREADY}, 0);
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, wdata, dummy);
  endtask

  task automatic check_stat(input string tag);
    logic [31:0] d;
    apb_xfer(1'b0, 4'h0, '0, d);
    check(tag, d, exp_stat());
  endtask

  task automatic check_rxd(input string tag);
    logic [31:0] d, e;
    apb_xfer(1'b0, 4'h4, '0, d);
    e = (exp_q.size() > 0) ? {24'b0, exp_q.pop_front()} : 32'd0;
    check(tag, d, e);
  endtask

  // Drives one frame, one bit per BITC edges, then leaves the line idle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic pflip);
    logic [10:0] bits;
    if (PB == 1) bits = {stop, ^data ^ pflip, data, 1'b0};
    else         bits = {1'b1, stop, data, 1'b0};
    for (int i = 0; i < 10 + PB; i++) begin
      @(posedge PCLK); #1;
      rx = bits[i];
      repeat (BITC - 1) @(posedge PCLK);
    end
    #1 rx = 1'b1;
  endtask

  task automatic send_and_model(input logic [7:0] data, input logic stop, input logic pflip);
    logic bad_par;
    send_frame(data, stop, pflip);
    bad_par = (PB == 1) && pflip;
    if (bad_par) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    else if (!bad_par) begin
      if (exp_q.size() == DEPTH) m_ovr = 1'b1;
      else exp_q.push_back(data);
    end
  endtask

  task automatic pulse_reset();
    @(posedge PCLK); #1 PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  head;

    // Reset state
    repeat (4) @(posedge PCLK);
    #1 PRESET = 1'b0;
    check("reset_prdata", PRDATA, 0);
    check("reset_pready", {31'b0, PREADY}, 0);
    check_stat("reset_stat");

    // Single good frame
    repeat (100) @(posedge PCLK);
    send_and_model(8'hA5, 1'b1, 1'b0);
    check_stat("a5_stat_full_entry");
    check_rxd("a5_rxd");
    check_stat("a5_stat_after_pop");

    // Start-bit glitch shorter than half a bit
    @(posedge PCLK); #1 rx = 1'b0;
    repeat (5 * DIV) @(posedge PCLK);
    #1 rx = 1'b1;
    repeat (2 * BITC) @(posedge PCLK);
    check_stat("glitch_stat");
    check_rxd("glitch_rxd_empty");

    // Framing error and W1C
    send_and_model(8'h3C, 1'b0, 1'b0);
    repeat (BITC) @(posedge PCLK);
    check_stat("ferr_stat");
    apb_write(4'h0, 32'h8);
    m_ferr = 1'b0;
    check_stat("ferr_cleared");

    // Overflow: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_and_model(8'(i), 1'b1, 1'b0);
    check_stat("ovr_stat");
    apb_write(4'h4, 32'hFF);
    apb_xfer(1'b0, 4'h8, '0, d);
    check("reg2_reads_zero", d, 0);
    for (int i = 0; i < 5; i++) check_rxd("ovr_drain");
    check_stat("ovr_after_drain");
    apb_write(4'h0, 32'hFFFF_FFFF);
    m_ovr = 1'b0;
    check_stat("ovr_cleared");

    // Push into a full FIFO on the same edge as an RXD pop: no overrun
    pulse_reset();
    clear_model();
    while (cyc % DIV != 0) begin
      @(posedge PCLK); #1;
    end
    for (int i = 0; i < DEPTH; i++) send_and_model(8'h11 + 8'(i), 1'b1, 1'b0);
    head = exp_q.pop_front();
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (PUSH_OFS - 2) @(posedge PCLK);
        apb_xfer(1'b0, 4'h4, '0, d);
      end
    join
    check("simul_pop_data", d, {24'b0, head});
    check_stat("simul_stat_full_no_ovr");
    for (int i = 0; i < DEPTH; i++) check_rxd("simul_drain");
    check_stat("simul_empty");

    // Reset in the middle of data bit 4
    send_and_model(8'h5A, 1'b1, 1'b0);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BITC * 5 + BITC / 2) @(posedge PCLK);
        #1 PRESET = 1'b1;
        @(posedge PCLK); #1 PRESET = 1'b0;
      end
    join
    clear_model();
    check_stat("midreset_stat");
    send_and_model(8'h12, 1'b1, 1'b0);
    check_stat("midreset_one_entry");
    check_rxd("midreset_rxd");
    check_rxd("midreset_rxd_empty");

`ifdef UART_RX_PARITY_EN
    // Bad parity drops the byte; good parity passes it
    send_and_model(8'h03, 1'b1, 1'b1);
    check_stat("perr_stat");
    send_and_model(8'h03, 1'b1, 1'b0);
    check_rxd("parity_ok_rxd");
    apb_write(4'h0, 32'h10);
    m_perr = 1'b0;
    check_stat("perr_cleared");
`else
    apb_write(4'h0, 32'h10);
    check_stat("perr_w1c_no_effect");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
